vga_balayage: RTL



---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_balayage_tick_pixel.sv | 31 +++
 rtl/vga_balayage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour type and named colours for the raster generator.
// The colour-bar helper is only referenced when VGA_MIRE_EN is defined.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [4:0] couleur_t;

  localparam couleur_t NOIR  = 5'b00000;
  localparam couleur_t JAUNE = 5'b11000;
  localparam couleur_t BLANC = 5'b11111;

  // Eight vertical bars, 128 pixels wide each.
  function automatic couleur_t mire_couleur(input logic [2:0] barre);
    couleur_t c;
    case (barre)
      3'd0:    c = 5'b00000;
      3'd1:    c = 5'b00011;
      3'd2:    c = 5'b01100;
      3'd3:    c = 5'b01111;
      3'd4:    c = 5'b10000;
      3'd5:    c = 5'b10011;
      3'd6:    c = 5'b11000;
      default: c = 5'b11111;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_balayage_tick_pixel.sv
// Pixel-tick divider: counts 0..DIV_PIXEL-1 and flags the last count.
// With DIV_PIXEL=1 the counter stays at 0 and the tick is permanently high.
module tick_pixel #(
  parameter int DIV_PIXEL = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [3:0] DIV_MAX = 4'(DIV_PIXEL - 1);

  if ((DIV_PIXEL < 1) || (DIV_PIXEL > 16)) begin : g_div_range
    $error("tick_pixel: DIV_PIXEL must be within 1..16");
  end

  logic [3:0] div_q, div_d;

  always_comb begin
    div_d = div_q + 4'd1;
    if (div_q == DIV_MAX) div_d = 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= 4'd0;
    else        div_q <= div_d;
  end

  assign tick = (div_q == DIV_MAX);

endmodule

// File: rtl/vga_balayage.sv
// VGA raster timing generator: scan counters, registered sync/blanking and frame-start pulse.
// Optional macro VGA_MIRE_EN replaces the couleur input by an internal colour-bar pattern.
module vga_balayage
  import vga_pkg::*;
#(
  parameter int DIV_PIXEL  = 2,
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int SYNC_ACTIF = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] hpos,
  output logic [10:0] vpos,
  input  logic [4:0]  couleur,
  output logic        hsync,
  output logic        vsync,
  output logic        actif,
  output logic [4:0]  couleur_out,
  output logic        debut_trame
);

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOT > 2048) begin : g_h_range
    $error("vga_balayage: H total exceeds 2048");
  end
  if (V_TOT > 2048) begin : g_v_range
    $error("vga_balayage: V total exceeds 2048");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] H_SY_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SY_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SY_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SY_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        SYNC_LVL = (SYNC_ACTIF != 0);

  logic tick;

  tick_pixel #(.DIV_PIXEL(DIV_PIXEL)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic [10:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        actif_q, actif_d, debut_q, debut_d;
  couleur_t    couleur_q, couleur_d;
  couleur_t    source;
  logic        fin_ligne, fin_trame;

`ifdef VGA_MIRE_EN
  assign source = mire_couleur(hpos_q[9:7]);
`else
  assign source = couleur;
`endif

  assign fin_ligne = (hpos_q == H_LAST);
  assign fin_trame = fin_ligne && (vpos_q == V_LAST);

  always_comb begin
    hpos_d    = hpos_q;
    vpos_d    = vpos_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    actif_d   = actif_q;
    couleur_d = couleur_q;
    debut_d   = 1'b0;
    if (tick) begin
      hpos_d = fin_ligne ? 11'd0 : hpos_q + 11'd1;
      if (fin_ligne) vpos_d = (vpos_q == V_LAST) ? 11'd0 : vpos_q + 11'd1;
      // Output stage samples the position being left, so it trails the counters by one tick.
      actif_d   = (hpos_q < H_VIS) && (vpos_q < V_VIS);
      hsync_d   = ((hpos_q >= H_SY_BEG) && (hpos_q < H_SY_END)) ? SYNC_LVL : ~SYNC_LVL;
      vsync_d   = ((vpos_q >= V_SY_BEG) && (vpos_q < V_SY_END)) ? SYNC_LVL : ~SYNC_LVL;
      couleur_d = actif_d ? source : NOIR;
      debut_d   = fin_trame;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q    <= 11'd0;
      vpos_q    <= 11'd0;
      hsync_q   <= ~SYNC_LVL;
      vsync_q   <= ~SYNC_LVL;
      actif_q   <= 1'b0;
      couleur_q <= NOIR;
      debut_q   <= 1'b0;
    end else begin
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      actif_q   <= actif_d;
      couleur_q <= couleur_d;
      debut_q   <= debut_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign actif       = actif_q;
  assign couleur_out = couleur_q;
  assign debut_trame = debut_q;

endmodule
